// File: rtl/dmem_mmio_pkg.sv
// Shared address map and STATUS layout for the data-memory responder.
// Imported by the top and by the bench.
package dmem_mmio_pkg;

  localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

  typedef enum logic [1:0] {
    OFF_LED  = 2'd0,
    OFF_TX   = 2'd1,
    OFF_STAT = 2'd2,
    OFF_CYC  = 2'd3
  } mmio_off_e;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_CNT_LSB = 3;

endpackage

// File: rtl/tx_byte_fifo.sv
// Byte FIFO feeding the TX consumer; dout shows the head byte, or 0 when empty.
// Storage is not reset, only the pointers and count.
module tx_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [7:0]             din,
  input  logic                   pop,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_do_pop;
  logic w_do_push;

  assign empty = (r_count == '0);
  assign full  = (r_count == (AW+1)'(DEPTH));
  assign count = r_count;
  assign dout  = empty ? 8'h00 : r_mem[r_rd_ptr];

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

  // NOTE: data storage is deliberately left out of reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder for a single-cycle core: word RAM below 0x8000_0000,
// LED / TX FIFO / STATUS / CYCLE registers in the MMIO page above it.
module dmem_mmio_responder
  import dmem_mmio_pkg::*;
#(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int LED_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWrite,
  input  logic [31:0]      DataAdr,
  input  logic [31:0]      WriteData,
  output logic [31:0]      ReadData,
  output logic [LED_W-1:0] leds,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready
);

  localparam int RAM_AW  = $clog2(RAM_WORDS);
  localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]      r_ram [RAM_WORDS];
  logic [LED_W-1:0] r_leds;
  logic             r_ovf;
  logic [31:0]      r_cycle;

  logic              w_is_ram;
  logic              w_mmio_sel;
  mmio_off_e         w_off;
  logic [RAM_AW-1:0] w_ram_idx;
  logic              w_wr;
  logic              w_wr_ram;
  logic              w_wr_led;
  logic              w_wr_tx;
  logic              w_wr_stat;
  logic              w_wr_cyc;
  logic              w_full;
  logic              w_empty;
  logic [FIFO_CW-1:0] w_count;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [31:0]       w_status;
  logic              w_unused_addr_lsbs;

  assign w_unused_addr_lsbs = ^DataAdr[1:0];

  // Only offsets 0x0..0xC of the MMIO page decode; anything else above bit 3 is a hole.
  assign w_is_ram   = !DataAdr[31];
  assign w_mmio_sel = DataAdr[31] && (DataAdr[30:4] == 27'd0);
  assign w_off      = mmio_off_e'(DataAdr[3:2]);
  assign w_ram_idx  = DataAdr[RAM_AW+1:2];

  assign w_wr      = MemWrite && reset;
  assign w_wr_ram  = w_wr && w_is_ram;
  assign w_wr_led  = w_wr && w_mmio_sel && (w_off == OFF_LED);
  assign w_wr_tx   = w_wr && w_mmio_sel && (w_off == OFF_TX);
  assign w_wr_stat = w_wr && w_mmio_sel && (w_off == OFF_STAT);
  assign w_wr_cyc  = w_wr && w_mmio_sel && (w_off == OFF_CYC);

  assign tx_valid = !w_empty;
  assign w_pop    = tx_valid && tx_ready;
  assign w_push   = w_wr_tx && (!w_full || w_pop);
  assign w_drop   = w_wr_tx && w_full && !w_pop;

  tx_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .din   (WriteData[7:0]),
    .pop   (w_pop),
    .dout  (tx_data),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_ff @(posedge clk) begin
    if (w_wr_ram) r_ram[w_ram_idx] <= WriteData;
  end

  // A dropped byte sets ovf even if the same cycle also clears it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_leds  <= '0;
      r_ovf   <= 1'b0;
      r_cycle <= '0;
    end else begin
      if (w_wr_led) r_leds <= WriteData[LED_W-1:0];
      if (w_drop)         r_ovf <= 1'b1;
      else if (w_wr_stat) r_ovf <= 1'b0;
      if (w_wr_cyc) r_cycle <= '0;
      else          r_cycle <= r_cycle + 32'd1;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_status = '0;
    w_status[STAT_FULL]  = w_full;
    w_status[STAT_EMPTY] = w_empty;
    w_status[STAT_OVF]   = r_ovf;
    w_status[STAT_CNT_LSB +: FIFO_CW] = w_count;
  end

  always_comb begin
    ReadData = '0;
    if (w_is_ram) begin
      ReadData = r_ram[w_ram_idx];
    end else if (w_mmio_sel) begin
      unique case (w_off)
        OFF_LED:  ReadData = 32'(r_leds);
        OFF_TX:   ReadData = '0;
        OFF_STAT: ReadData = w_status;
        OFF_CYC:  ReadData = r_cycle;
      endcase
    end
  end

  assign leds = r_leds;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: a vector table for RAM/LED/decode,
// then hand-written sequences for the FIFO, reset and CYCLE corner cases.
module tb_dmem_mmio_responder;

  localparam logic [31:0] A_LED  = 32'h8000_0000;
  localparam logic [31:0] A_TX   = 32'h8000_0004;
  localparam logic [31:0] A_STAT = 32'h8000_0008;
  localparam logic [31:0] A_CYC  = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  leds;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [7:0]  exp_leds;
  } vec_t;

  vec_t vecs[$];

  dmem_mmio_responder #(
    .RAM_WORDS  (64),
    .FIFO_DEPTH (4),
    .LED_W      (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .leds      (leds),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] wd);
    MemWrite  = we;
    DataAdr   = adr;
    WriteData = wd;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [31:0] adr, input logic [31:0] exp);
    drive(1'b0, adr, 32'h0);
    check(name, ReadData, exp);
  endtask

  initial begin
    reset     = 1'b0;
    MemWrite  = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
    tx_ready  = 1'b0;
    step();
    step();
    check("rst_leds", 32'(leds), 32'h0);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    read_chk("rst_status", A_STAT, 32'h02);
    read_chk("rst_cycle", A_CYC, 32'h0);
    reset = 1'b1;

    // RAM, aliasing, LED and unmapped-MMIO vectors.
    vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         8'h00});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 8'h00});
    vecs.push_back('{1'b0, 32'h0000_0110, 32'h0,         32'hDEAD_BEEF, 8'h00});
    vecs.push_back('{1'b0, 32'h4000_0013, 32'h0,         32'hDEAD_BEEF, 8'h00});
    vecs.push_back('{1'b1, 32'h0000_0014, 32'h1234_5678, 32'h0,         8'h00});
    vecs.push_back('{1'b0, 32'h0000_0014, 32'h0,         32'h1234_5678, 8'h00});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 8'h00});
    vecs.push_back('{1'b1, A_LED,         32'h0000_01A5, 32'h0,         8'hA5});
    vecs.push_back('{1'b0, A_LED,         32'h0,         32'h0000_00A5, 8'hA5});
    vecs.push_back('{1'b0, A_TX,          32'h0,         32'h0,         8'hA5});
    vecs.push_back('{1'b0, 32'h8000_0010, 32'h0,         32'h0,         8'hA5});
    vecs.push_back('{1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 32'h0,         8'hA5});
    vecs.push_back('{1'b0, 32'h8000_0010, 32'h0,         32'h0,         8'hA5});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 8'hA5});
    vecs.push_back('{1'b1, 32'h8000_0020, 32'h0000_0033, 32'h0,         8'hA5});
    vecs.push_back('{1'b1, 32'h8000_0044, 32'h0000_0099, 32'h0,         8'hA5});
    vecs.push_back('{1'b0, A_STAT,        32'h0,         32'h0000_0002, 8'hA5});
    vecs.push_back('{1'b0, A_LED,         32'h0,         32'h0000_00A5, 8'hA5});

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].adr, vecs[i].wd);
      if (!vecs[i].we) check($sformatf("vec%0d_rd", i), ReadData, vecs[i].exp_rd);
      step();
      check($sformatf("vec%0d_leds", i), 32'(leds), 32'(vecs[i].exp_leds));
    end
    check("hole_no_push", 32'(tx_valid), 32'h0);

    // Fill with consumer stalled, overflow, then drain.
    tx_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      drive(1'b1, A_TX, 32'h0000_0041 + 32'(b));
      step();
    end
    check("fill_head", 32'(tx_data), 32'h41);
    read_chk("fill_status", A_STAT, 32'h21);
    drive(1'b1, A_TX, 32'h0000_0045);
    step();
    read_chk("ovf_status", A_STAT, 32'h25);
    tx_ready = 1'b1;
    read_chk("pop_old_count", A_STAT, 32'h25);
    for (int b = 0; b < 4; b++) begin
      check($sformatf("drain_valid%0d", b), 32'(tx_valid), 32'h1);
      check($sformatf("drain_data%0d", b), 32'(tx_data), 32'h41 + 32'(b));
      step();
    end
    check("drained_valid", 32'(tx_valid), 32'h0);
    check("drained_data", 32'(tx_data), 32'h0);
    read_chk("drained_status", A_STAT, 32'h06);
    drive(1'b1, A_STAT, 32'h0);
    step();
    read_chk("ovf_cleared", A_STAT, 32'h02);

    // Push into a full FIFO while the head leaves.
    tx_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      drive(1'b1, A_TX, 32'h0000_0011 + 32'(b));
      step();
    end
    tx_ready = 1'b1;
    drive(1'b1, A_TX, 32'h0000_0055);
    check("fullpush_head", 32'(tx_data), 32'h11);
    step();
    read_chk("fullpush_status", A_STAT, 32'h21);
    begin
      logic [7:0] exp_seq [4];
      exp_seq = '{8'h12, 8'h13, 8'h14, 8'h55};
      for (int b = 0; b < 4; b++) begin
        check($sformatf("fullpush_data%0d", b), 32'(tx_data), 32'(exp_seq[b]));
        step();
      end
    end
    check("fullpush_empty", 32'(tx_valid), 32'h0);
    read_chk("fullpush_end_status", A_STAT, 32'h02);

    // Push into an empty FIFO with consumer ready: valid rises only after the edge.
    drive(1'b1, A_TX, 32'h0000_0066);
    check("emptypush_valid_pre", 32'(tx_valid), 32'h0);
    step();
    check("emptypush_valid", 32'(tx_valid), 32'h1);
    check("emptypush_data", 32'(tx_data), 32'h66);
    read_chk("emptypush_status", A_STAT, 32'h08);
    step();
    check("emptypush_drained", 32'(tx_valid), 32'h0);

    // Reset mid-drain, with a write presented that must be ignored.
    tx_ready = 1'b0;
    drive(1'b1, A_TX, 32'h0000_0077);
    step();
    drive(1'b1, A_TX, 32'h0000_0078);
    step();
    tx_ready = 1'b1;
    reset = 1'b0;
    drive(1'b1, A_LED, 32'h0000_0077);
    step();
    reset = 1'b1;
    check("rst2_leds", 32'(leds), 32'h0);
    check("rst2_tx_valid", 32'(tx_valid), 32'h0);
    check("rst2_tx_data", 32'(tx_data), 32'h0);
    read_chk("rst2_status", A_STAT, 32'h02);
    read_chk("rst2_cycle", A_CYC, 32'h0);
    read_chk("rst2_ram_kept", 32'h0000_0010, 32'hDEAD_BEEF);

    // CYCLE counting, clear-on-write and wrap.
    repeat (5) step();
    read_chk("cycle_n5", A_CYC, 32'd5);
    drive(1'b1, A_CYC, 32'h0000_1234);
    step();
    read_chk("cycle_cleared", A_CYC, 32'd0);
    step();
    read_chk("cycle_after_clr", A_CYC, 32'd1);
    dut.r_cycle = 32'hFFFF_FFFF;
    read_chk("cycle_forced", A_CYC, 32'hFFFF_FFFF);
    step();
    read_chk("cycle_wrap", A_CYC, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
